// File: rtl/spatz_mem_responder.sv
// Memory-side endpoint for the Spatz VLSU port: ELEN-wide local SRAM, one in-order response per request.
// Latency: response valid the cycle after request accept when nothing older is pending.
// Backpressure: at most FifoDepth responses outstanding; request ready drops until one is handed off.

package spatz_mem_pkg;
    localparam int unsigned ELEN      = 32;
    localparam int unsigned ELENB     = ELEN / 8;
    localparam int unsigned NRVREG    = 32;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned IdWidth   = $clog2(NRVREG) + 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [1:0]           mode;
        logic [1:0]           size;
        logic                 we;
        logic [ELENB-1:0]     strb;
        logic [ELEN-1:0]      wdata;
        logic                 last;
        logic                 spec;
    } spatz_mem_req_t;

    typedef struct packed {
        logic [$clog2(NRVREG)-1:0] id;
        logic [ELEN-1:0]           rdata;
        logic                      err;
    } spatz_mem_resp_t;

    typedef struct packed {
        logic            last;
        spatz_mem_resp_t resp;
    } spatz_mem_entry_t;
endpackage

// Generic circular FIFO; Depth must be a power of two and at least 2.
// Latency: pushed data visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module spatz_mem_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push_vld,
    input  logic [Width-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic             o_empty,
    output logic [Width-1:0] o_head_dat
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [PtrW:0]    r_cnt;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full     = (r_cnt == (PtrW+1)'(Depth));
    assign o_empty    = (r_cnt == '0);
    assign w_push     = i_push_vld & ~w_full;
    assign w_pop      = i_pop_rdy & ~o_empty;
    assign o_head_dat = r_mem[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_push_dat;
    end
endmodule

// Spatz memory responder top: SRAM read/write at accept, stage register, response FIFO with bypass.
// Latency: 1 cycle from request accept to response valid when idle; 1 request/cycle sustained.
// Backpressure: mem_req_ready_o = in_flight < FifoDepth, independent of mem_req_valid_i.
module spatz_mem_responder
    import spatz_mem_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned FifoDepth = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  spatz_mem_req_t  mem_req_i,
    input  logic            mem_req_valid_i,
    output logic            mem_req_ready_o,
    output spatz_mem_resp_t mem_resp_o,
    output logic            mem_resp_valid_o,
    input  logic            mem_resp_ready_i,
    output logic            burst_done_o,
    output logic [15:0]     burst_cnt_o
);
    localparam int unsigned IdxW = $clog2(NumWords);
    localparam int unsigned OffW = $clog2(ELENB);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam logic [AddrWidth:0] MemBytes = (AddrWidth+1)'(NumWords * ELENB);

    logic [ELEN-1:0]  r_mem [NumWords];
    logic [CntW-1:0]  r_in_flight;
    spatz_mem_entry_t r_stg;
    logic             r_stg_vld;
    logic             r_burst_done;
    logic [15:0]      r_burst_cnt;

    logic             w_req_hs;
    logic             w_resp_hs;
    logic [3:0]       w_bytes;
    logic             w_oob;
    logic             w_misalign;
    logic             w_too_wide;
    logic             w_fault;
    logic [IdxW-1:0]  w_idx;
    spatz_mem_entry_t w_stg_nxt;
    spatz_mem_entry_t w_fifo_head;
    logic             w_fifo_empty;
    logic             w_stg_take;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_out_last;
    logic             w_unused_id_msb;

    assign w_unused_id_msb = mem_req_i.id[IdWidth-1];

    assign mem_req_ready_o = (r_in_flight < CntW'(FifoDepth));
    assign w_req_hs        = mem_req_valid_i & mem_req_ready_o;
    assign w_resp_hs       = mem_resp_valid_o & mem_resp_ready_i;

    assign w_bytes    = 4'(1) << mem_req_i.size;
    assign w_oob      = ({1'b0, mem_req_i.addr} >= MemBytes);
    assign w_misalign = ((mem_req_i.addr[3:0] & (w_bytes - 4'd1)) != 4'd0);
    assign w_too_wide = (w_bytes > 4'(ELENB));
    assign w_fault    = w_oob | w_misalign | w_too_wide | (mem_req_i.mode != 2'd0);
    assign w_idx      = mem_req_i.addr[OffW +: IdxW];

    always_comb begin
        w_stg_nxt          = '0;
        w_stg_nxt.last     = mem_req_i.last;
        w_stg_nxt.resp.id  = mem_req_i.id[IdWidth-2:0];
        w_stg_nxt.resp.err = w_fault & ~mem_req_i.spec;
        if (!w_fault && !mem_req_i.we) w_stg_nxt.resp.rdata = r_mem[w_idx];
    end

    // Byte-strobed write lands at the accept edge so a read accepted next cycle sees it.
    always_ff @(posedge clk_i) begin
        if (w_req_hs && mem_req_i.we && !w_fault) begin
            for (int i = 0; i < int'(ELENB); i++) begin
                if (mem_req_i.strb[i]) r_mem[w_idx][8*i +: 8] <= mem_req_i.wdata[8*i +: 8];
            end
        end
    end

    // The stage entry never lingers: it is either handed off directly or parked in the FIFO.
    assign w_stg_take  = r_stg_vld & w_fifo_empty & mem_resp_ready_i;
    assign w_fifo_push = r_stg_vld & ~w_stg_take;
    assign w_fifo_pop  = ~w_fifo_empty & mem_resp_ready_i;

    assign mem_resp_valid_o = ~w_fifo_empty | r_stg_vld;
    assign mem_resp_o       = w_fifo_empty ? r_stg.resp : w_fifo_head.resp;
    assign w_out_last       = w_fifo_empty ? r_stg.last : w_fifo_head.last;

    spatz_mem_fifo #(
        .Width ($bits(spatz_mem_entry_t)),
        .Depth (FifoDepth)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push_vld (w_fifo_push),
        .i_push_dat (r_stg),
        .i_pop_rdy  (w_fifo_pop),
        .o_empty    (w_fifo_empty),
        .o_head_dat (w_fifo_head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stg_vld    <= 1'b0;
            r_stg        <= '0;
            r_in_flight  <= '0;
            r_burst_done <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            r_stg_vld <= w_req_hs;
            if (w_req_hs) r_stg <= w_stg_nxt;
            case ({w_req_hs, w_resp_hs})
                2'b10:   r_in_flight <= r_in_flight + 1'b1;
                2'b01:   r_in_flight <= r_in_flight - 1'b1;
                default: r_in_flight <= r_in_flight;
            endcase
            r_burst_done <= w_resp_hs & w_out_last;
            if (w_resp_hs && w_out_last) r_burst_cnt <= r_burst_cnt + 16'd1;
        end
    end

    assign burst_done_o = r_burst_done;
    assign burst_cnt_o  = r_burst_cnt;
endmodule

// File: doc/spatz_mem_responder.md
# spatz_mem_responder

Memory-side endpoint of the Spatz VLSU memory port: consumes `spatz_mem_req_t` requests and returns exactly one `spatz_mem_resp_t` response per request, in order. Backed by a single-ported, ELEN-wide local SRAM with byte-strobed writes, range and alignment checking, and speculative-fault suppression. Serves as the TCDM-less memory model for VLSU unit benches and as a scratchpad endpoint in small Spatz configurations.

## Interface
- `NumWords`, 1024: SRAM depth in ELEN-bit words; power of two.
- `FifoDepth`, 2: max outstanding (accepted, not yet handed off) responses; ≥2; power of two.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `mem_req_i` in `spatz_mem_req_t`: request payload.
- `mem_req_valid_i` in 1: request valid.
- `mem_req_ready_o` out 1: request ready.
- `mem_resp_o` out `spatz_mem_resp_t`: response payload.
- `mem_resp_valid_o` out 1: response valid.
- `mem_resp_ready_i` in 1: response ready.
- `burst_done_o` out 1: one-cycle pulse on handshake of a response whose request had `last`=1.
- `burst_cnt_o` out 16: count of such handshakes, wraps at 2^16.

## Operation
- Request accepted on edge where `mem_req_valid_i & mem_req_ready_o`. Response accepted on edge where `mem_resp_valid_o & mem_resp_ready_i`.
- `in_flight` counter (0..FifoDepth): +1 on request accept, −1 on response accept, both same cycle → unchanged. `mem_req_ready_o = (in_flight < FifoDepth)`; never depends on `mem_req_valid_i`.
- Word index = `addr >> $clog2(ELENB)`. Error conditions (any → fault):
  - `addr >= NumWords*ELENB`;
  - `addr & ((1<<size)-1) != 0` (misaligned);
  - `(1<<size) > ELENB`;
  - `mode != 0`.
- Non-faulting write (`we`=1): bytes with `strb[i]`=1 updated from `wdata[8i+7:8i]` at the accept edge; response `rdata`=0.
- Non-faulting read: `rdata` = full ELEN-bit word at the index, as stored after all earlier accepted writes; `strb`, `wdata` ignored.
- Faulting request: no SRAM write; `rdata`=0; `err` = `~spec` (speculative faults return `err`=0).
- Response `id` = request `id[$clog2(NRVREG)-1:0]` (MSB dropped).
- Responses leave in strict acceptance order. Pipeline: SRAM stage register (1 entry) → response FIFO; output is FIFO head, or the stage register when FIFO is empty (bypass). Stage register moves into FIFO when it is not consumed directly. Total storage never exceeds FifoDepth due to `in_flight` gating.
- `last` travels with the entry; `burst_done_o`/`burst_cnt_o` update on its response handshake.
- `mem_resp_o` held stable while `mem_resp_valid_o`=1 and `mem_resp_ready_i`=0.

## Timing
- Reset (async assert, sync-safe deassert): `mem_req_ready_o`=1, `mem_resp_valid_o`=0, `mem_resp_o`=0, `burst_done_o`=0, `burst_cnt_o`=0, `in_flight`=0, FIFO empty. SRAM contents not reset.
- Reset mid-operation: all outstanding responses discarded; SRAM writes already accepted are kept.
- Latency: request accepted at edge t → response valid in cycle after t (1 cycle) when nothing older is pending.
- Throughput: 1 request/cycle sustained with `mem_resp_ready_i` held 1 and FifoDepth ≥ 2.
- Backpressure: with `mem_resp_ready_i`=0, exactly FifoDepth requests accepted, then `mem_req_ready_o`=0 until the first response handshake; it returns to 1 in the cycle after that edge.
- Write then read of same address on consecutive accepts: read returns new data.
- `burst_done_o` asserted in the cycle following the handshake edge of the `last` response; `burst_cnt_o` updated at the same edge.

## Test plan
- Reset/idle: hold `rst_ni`=0 → ready=1, resp_valid=0, burst_cnt=0; release, no requests → outputs unchanged.
- Write/read, ELEN=32: write addr 0x10, wdata 0xDEADBEEF, strb 0xF; write addr 0x10, wdata 0x000000AA, strb 0x1; read 0x10 → rdata 0xDEADBEAA, err=0, ids echoed, responses 1 cycle after each accept, back-to-back.
- Faults: read addr NumWords*ELENB → err=1, rdata=0; same with spec=1 → err=0, rdata=0; write addr 0x2, size 2 → err=1 and later read of 0x0 shows word unchanged; mode=1 → err=1.
- Backpressure: resp_ready=0, stream 5 reads with ids 1..5 → exactly 2 accepted, ready=0; then resp_ready=1 → ids 1..5 returned in order, no loss or duplication.
- Burst count: 3 bursts of 4 requests, `last` on 4th → burst_done pulses 3 times, burst_cnt=3; random resp_ready stalls do not change the count.
- Reset mid-stream: 2 responses pending, pulse rst_ni → resp_valid=0 immediately, in_flight cleared, subsequent read returns previously written data.
